// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD arithmetic datapath:
// digit width, radix, digit type, FSM state encoding and a digit validity helper.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_RADIX   = 10;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic logic bcd_digit_is_valid(input bcd_digit_t d);
        return d < bcd_digit_t'(BCD_RADIX);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit radix-10 subtractor: d = x - y - borrow_in, wrapped into 0..9
// by adding the radix back whenever the raw difference goes negative.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  bcd_digit_t x,
    input  bcd_digit_t y,
    input  logic       borrow_in,
    output bcd_digit_t d,
    output logic       borrow_out
);

    logic [5:0] t;

    // Raw values are used even for non-BCD digits, so 0xA - 0 stays 0xA.
    assign t          = {2'b00, x} - {2'b00, y} - {5'b00000, borrow_in};
    assign borrow_out = |t[5:4];
    assign d          = borrow_out ? (t[3:0] + bcd_digit_t'(BCD_RADIX)) : t[3:0];

endmodule

// File: rtl/bcd_sub16_serial.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin, one digit per clock,
// least-significant digit first, with valid/ready handshakes on both sides.
module bcd_sub16_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    input  logic                      bin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] diff,
    output logic                      bout,
    output logic                      invalid
);

    localparam int W     = BCD_DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           state;
    state_t           next_state;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [IDX_W-1:0] idx;
    logic             borrow;
    logic             accept;
    logic             operands_bad;
    bcd_digit_t       x_cur;
    bcd_digit_t       y_cur;
    bcd_digit_t       d_cur;
    logic             borrow_nxt;

    assign accept = in_valid & in_ready;
    assign x_cur  = a_q[idx*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign y_cur  = b_q[idx*BCD_DIGIT_W +: BCD_DIGIT_W];

    bcd_digit_sub u_digit (
        .x          (x_cur),
        .y          (y_cur),
        .borrow_in  (borrow),
        .d          (d_cur),
        .borrow_out (borrow_nxt)
    );

    always_comb begin
        operands_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_is_valid(a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
                !bcd_digit_is_valid(b[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                operands_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = CALC;
            CALC:    if (idx == LAST_IDX) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Results are only touched on accept and during CALC, so they stay put
    // through DONE and the following IDLE until the next operation starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            borrow  <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            invalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b;
                        borrow  <= bin;
                        idx     <= '0;
                        diff    <= '0;
                        bout    <= 1'b0;
                        invalid <= operands_bad;
                    end
                end
                CALC: begin
                    diff[idx*BCD_DIGIT_W +: BCD_DIGIT_W] <= d_cur;
                    borrow <= borrow_nxt;
                    if (idx == LAST_IDX) begin
                        bout <= borrow_nxt;
                        idx  <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
